// File: rtl/hls_bus_pkg.sv
// Shared types for the HLS bus arbiter: arbitration FSM states and the
// command payload bundle muxed from the two masters onto the bridge.
package hls_bus_pkg;

  localparam int ID_W       = 1;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] data;
    logic [3:0]            mask;
    logic                  write;
    logic                  uncached;
    logic [2:0]            size;
    logic                  last;
  } cmd_pl_t;

endpackage

// File: rtl/hls_arb_id_fifo.sv
// In-order source-ID FIFO: one entry per outstanding read burst, popped on
// the final response beat. DEPTH must be a power of two so pointers wrap.
module hls_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only valid entries (count) are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hls_bus_arbiter.sv
// Two-master round-robin arbiter in front of the HLS bridge, burst-locked,
// with in-order response steering. HLS_ARB_ERR_EN adds err_orphan/err_overflow.
module hls_bus_arbiter
  import hls_bus_pkg::*;
#(
  parameter int DATA_WIDTH      = BUS_DATA_W,
  parameter int DATA_ADDR_WIDTH = BUS_ADDR_W,
  parameter int OUTST_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m0_cmd_valid,
  output logic                       m0_cmd_ready,
  input  logic [DATA_ADDR_WIDTH-1:0] m0_cmd_payload_address,
  input  logic [DATA_WIDTH-1:0]      m0_cmd_payload_data,
  input  logic [3:0]                 m0_cmd_payload_mask,
  input  logic                       m0_cmd_payload_write,
  input  logic                       m0_cmd_payload_uncached,
  input  logic [2:0]                 m0_cmd_payload_size,
  input  logic                       m0_cmd_payload_last,
  output logic                       m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]      m0_rsp_payload_data,
  output logic                       m0_rsp_payload_last,
  input  logic                       m1_cmd_valid,
  output logic                       m1_cmd_ready,
  input  logic [DATA_ADDR_WIDTH-1:0] m1_cmd_payload_address,
  input  logic [DATA_WIDTH-1:0]      m1_cmd_payload_data,
  input  logic [3:0]                 m1_cmd_payload_mask,
  input  logic                       m1_cmd_payload_write,
  input  logic                       m1_cmd_payload_uncached,
  input  logic [2:0]                 m1_cmd_payload_size,
  input  logic                       m1_cmd_payload_last,
  output logic                       m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]      m1_rsp_payload_data,
  output logic                       m1_rsp_payload_last,
  output logic                       s_cmd_valid,
  input  logic                       s_cmd_ready,
  output logic [DATA_ADDR_WIDTH-1:0] s_cmd_payload_address,
  output logic [DATA_WIDTH-1:0]      s_cmd_payload_data,
  output logic [3:0]                 s_cmd_payload_mask,
  output logic                       s_cmd_payload_write,
  output logic                       s_cmd_payload_uncached,
  output logic [2:0]                 s_cmd_payload_size,
  output logic                       s_cmd_payload_last,
  input  logic                       s_rsp_valid,
  input  logic [DATA_WIDTH-1:0]      s_rsp_payload_data,
  input  logic                       s_rsp_payload_last
`ifdef HLS_ARB_ERR_EN
  ,
  output logic                       err_orphan,
  output logic                       err_overflow
`endif
);

  localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  cmd_pl_t          pl0, pl1, sel_pl;
  logic             gnt;
  logic             elig0, elig1, req0, req1;
  logic             s_valid_int, fire;
  logic             push_req, push, pop;
  logic [ID_W-1:0]  id_head;
  logic             id_full, id_empty;
  logic [CNT_W-1:0] id_cnt;

  assign pl0 = '{address: m0_cmd_payload_address, data: m0_cmd_payload_data,
                 mask: m0_cmd_payload_mask, write: m0_cmd_payload_write,
                 uncached: m0_cmd_payload_uncached, size: m0_cmd_payload_size,
                 last: m0_cmd_payload_last};
  assign pl1 = '{address: m1_cmd_payload_address, data: m1_cmd_payload_data,
                 mask: m1_cmd_payload_mask, write: m1_cmd_payload_write,
                 uncached: m1_cmd_payload_uncached, size: m1_cmd_payload_size,
                 last: m1_cmd_payload_last};

  // Reads are held off while every response slot is spoken for; no pop bypass.
  assign elig0 = m0_cmd_payload_write | (id_cnt < CNT_W'(OUTST_DEPTH));
  assign elig1 = m1_cmd_payload_write | (id_cnt < CNT_W'(OUTST_DEPTH));
  assign req0  = m0_cmd_valid & elig0;
  assign req1  = m1_cmd_valid & elig1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // A stalled first beat also locks, so the bridge sees a stable payload.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (fire & sel_pl.last) rr_d = ~gnt;
        else if (s_valid_int)   state_d = gnt ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (fire & sel_pl.last) begin
          state_d = IDLE;
          rr_d    = ~gnt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = 1'b0;
    unique case (state_q)
      LOCK0:   gnt = 1'b0;
      LOCK1:   gnt = 1'b1;
      default: gnt = (req0 & req1) ? rr_q : (req1 & ~req0);
    endcase
  end

  assign sel_pl      = gnt ? pl1 : pl0;
  assign s_valid_int = gnt ? req1 : req0;
  assign fire        = s_valid_int & s_cmd_ready;

  // Handshake outputs are forced low while reset is asserted.
  assign s_cmd_valid  = s_valid_int & rst_n;
  assign m0_cmd_ready = rst_n & s_cmd_ready & ~gnt & elig0;
  assign m1_cmd_ready = rst_n & s_cmd_ready & gnt & elig1;

  assign s_cmd_payload_address  = sel_pl.address;
  assign s_cmd_payload_data     = sel_pl.data;
  assign s_cmd_payload_mask     = sel_pl.mask;
  assign s_cmd_payload_write    = sel_pl.write;
  assign s_cmd_payload_uncached = sel_pl.uncached;
  assign s_cmd_payload_size     = sel_pl.size;
  assign s_cmd_payload_last     = sel_pl.last;

  assign push_req = fire & ~sel_pl.write & sel_pl.last;
  assign push     = push_req & ~id_full;
  assign pop      = s_rsp_valid & s_rsp_payload_last & ~id_empty;

  hls_arb_id_fifo #(.DEPTH(OUTST_DEPTH), .WIDTH(ID_W)) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (gnt),
    .dout  (id_head),
    .full  (id_full),
    .empty (id_empty),
    .count (id_cnt)
  );

  // Beats arriving with no outstanding read are dropped on the floor.
  assign m0_rsp_valid        = s_rsp_valid & ~id_empty & (id_head == 1'b0);
  assign m1_rsp_valid        = s_rsp_valid & ~id_empty & (id_head == 1'b1);
  assign m0_rsp_payload_data = s_rsp_payload_data;
  assign m1_rsp_payload_data = s_rsp_payload_data;
  assign m0_rsp_payload_last = s_rsp_payload_last;
  assign m1_rsp_payload_last = s_rsp_payload_last;

`ifdef HLS_ARB_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (s_rsp_valid & id_empty) err_orphan   <= 1'b1;
      if (push_req & id_full)     err_overflow <= 1'b1;
    end
  end
`endif

endmodule
